// File: rtl/light_conflict_monitor.sv
// Safety monitor for the NS/EW light state machines: debounced conflict and illegal-aspect
// detection, a stuck-lamp watchdog, and a latched issue flag. Optional: LIGHT_MONITOR_SNAPSHOT_EN.
module light_conflict_monitor #(
  parameter int CONFLICT_CYCLES = 4,
  parameter int WATCHDOG_CYCLES = 1000000,
  parameter int ARM_CYCLES      = 16
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic [4:0] in_ns_lights,
  input  logic [4:0] in_ew_lights,
  input  logic       in_clear,
  output logic       out_issue,
  output logic [1:0] out_fault_code,
  output logic [7:0] out_fault_count,
  output logic       out_armed
`ifdef LIGHT_MONITOR_SNAPSHOT_EN
  ,
  output logic [9:0] out_snapshot
`endif
);

  localparam int DEB_W = $clog2(CONFLICT_CYCLES + 1);
  localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(CONFLICT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ARM     = 2'd0,
    S_MONITOR = 2'd1,
    S_SUSPECT = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [DEB_W-1:0] r_deb;
  logic [DEB_W-1:0] w_deb_nx;
  logic [WD_W-1:0]  r_wd;
  logic [WD_W-1:0]  w_wd_nx;
  logic [ARM_W-1:0] r_arm;
  logic [ARM_W-1:0] w_arm_nx;
  logic [9:0]       r_prev;
  logic             r_issue;
  logic [1:0]       r_code;
  logic [1:0]       w_code_nx;
  logic [7:0]       r_count;
  logic             w_enter_fault;
  logic             w_deb_done;
  logic             w_wd_fire;

  logic [9:0] w_lamps;
  logic       w_ns_go;
  logic       w_ew_go;
  logic       w_ns_ill;
  logic       w_ew_ill;
  logic       w_cross;
  logic       w_bad;
  logic       w_same;

  // Exactly one of {red, green, yellow} must be lit: odd parity and not all three.
  assign w_ns_ill = ~((^in_ns_lights[2:0]) & ~(&in_ns_lights[2:0]));
  assign w_ew_ill = ~((^in_ew_lights[2:0]) & ~(&in_ew_lights[2:0]));
  assign w_ns_go  = |in_ns_lights[3:1];
  assign w_ew_go  = |in_ew_lights[3:1];
  assign w_cross  = (w_ns_go & w_ew_go) | (in_ns_lights[4] & w_ew_go) | (in_ew_lights[4] & w_ns_go);
  assign w_bad    = w_cross | w_ns_ill | w_ew_ill;
  assign w_lamps  = {in_ew_lights, in_ns_lights};
  assign w_same   = (w_lamps == r_prev);

  always_comb begin
    w_state_nx    = r_state;
    w_deb_nx      = r_deb;
    w_wd_nx       = '0;
    w_arm_nx      = r_arm;
    w_code_nx     = r_code;
    w_enter_fault = 1'b0;
    w_deb_done    = 1'b0;
    w_wd_fire     = 1'b0;
    case (r_state)
      S_ARM: begin
        if (r_arm == ARM_LAST) begin
          w_state_nx = S_MONITOR;
        end else begin
          w_arm_nx = r_arm + 1'b1;
        end
      end
      S_MONITOR, S_SUSPECT: begin
        w_wd_nx   = w_same ? r_wd + 1'b1 : '0;
        w_wd_fire = w_same && (r_wd == WD_LAST);
        if (r_state == S_MONITOR) begin
          if (w_bad) begin
            w_deb_nx = DEB_W'(1);
            if (CONFLICT_CYCLES == 1) w_deb_done = 1'b1;
            else                      w_state_nx = S_SUSPECT;
          end
        end else if (w_bad) begin
          if (r_deb == DEB_LAST) w_deb_done = 1'b1;
          else                   w_deb_nx   = r_deb + 1'b1;
        end else begin
          w_state_nx = S_MONITOR;
          w_deb_nx   = '0;
        end
        // Debounced conflict/aspect faults outrank a simultaneous watchdog expiry.
        if (w_deb_done) begin
          w_state_nx    = S_FAULT;
          w_code_nx     = w_cross ? 2'd1 : 2'd2;
          w_enter_fault = 1'b1;
        end else if (w_wd_fire) begin
          w_state_nx    = S_FAULT;
          w_code_nx     = 2'd3;
          w_enter_fault = 1'b1;
        end
      end
      S_FAULT: begin
        if (in_clear && !w_bad) begin
          w_state_nx = S_MONITOR;
          w_code_nx  = 2'd0;
          w_deb_nx   = '0;
        end
      end
      default: w_state_nx = S_ARM;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_state <= S_ARM;
      r_deb   <= '0;
      r_wd    <= '0;
      r_arm   <= '0;
      r_prev  <= '0;
      r_issue <= 1'b0;
      r_code  <= 2'd0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_deb   <= w_deb_nx;
      r_wd    <= w_wd_nx;
      r_arm   <= w_arm_nx;
      r_prev  <= w_lamps;
      r_issue <= (w_state_nx == S_FAULT);
      r_code  <= w_code_nx;
      if (w_enter_fault && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
    end
  end

`ifdef LIGHT_MONITOR_SNAPSHOT_EN
  logic [9:0] r_snapshot;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_snapshot <= '0;
    end else if (w_enter_fault) begin
      r_snapshot <= w_lamps;
    end
  end

  assign out_snapshot = r_snapshot;
`endif

  assign out_issue       = r_issue;
  assign out_fault_code  = r_code;
  assign out_fault_count = r_count;
  assign out_armed       = (r_state != S_ARM);

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Randomized + directed bench for light_conflict_monitor against a rule-level reference model.
module tb_light_conflict_monitor;

  localparam int CC  = 4;
  localparam int WD  = 64;
  localparam int ARM = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] ns = 5'd0;
  logic [4:0] ew = 5'd0;
  logic       clr = 1'b0;
  logic       issue;
  logic [1:0] code;
  logic [7:0] cnt;
  logic       armed;
`ifdef LIGHT_MONITOR_SNAPSHOT_EN
  logic [9:0] snap;
`endif

  light_conflict_monitor #(
    .CONFLICT_CYCLES(CC),
    .WATCHDOG_CYCLES(WD),
    .ARM_CYCLES(ARM)
  ) dut (
    .in_clock(clk),
    .in_reset(rst_n),
    .in_ns_lights(ns),
    .in_ew_lights(ew),
    .in_clear(clr),
    .out_issue(issue),
    .out_fault_code(code),
    .out_fault_count(cnt),
    .out_armed(armed)
`ifdef LIGHT_MONITOR_SNAPSHOT_EN
    ,
    .out_snapshot(snap)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, expressed as elapsed/consecutive-cycle quantities.
  bit         m_armed;
  bit         m_fault;
  int         m_edges;
  int         m_bad_run;
  int         m_still_run;
  int         m_count;
  int         m_code;
  logic [9:0] m_prev;
  logic [9:0] m_snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit is_conflict(input logic [4:0] n, input logic [4:0] e);
    bit gn = (n[3:1] != 3'b000);
    bit ge = (e[3:1] != 3'b000);
    return (gn && ge) || (n[4] && ge) || (e[4] && gn);
  endfunction

  function automatic bit is_illegal(input logic [4:0] l);
    return $countones(l[2:0]) != 1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_fault = 0; m_edges = 0; m_bad_run = 0; m_still_run = 0;
    m_count = 0; m_code = 0; m_prev = '0; m_snap = '0;
  endtask

  task automatic model_step();
    logic [9:0] vec;
    bit same, c, bad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    vec  = {ew, ns};
    same = (vec == m_prev);
    m_prev = vec;
    c   = is_conflict(ns, ew);
    bad = c || is_illegal(ns) || is_illegal(ew);
    if (!m_armed) begin
      m_edges++;
      if (m_edges == ARM) m_armed = 1;
      m_bad_run = 0;
      m_still_run = 0;
    end else if (m_fault) begin
      if (clr && !bad) begin
        m_fault = 0; m_code = 0; m_bad_run = 0; m_still_run = 0;
      end
    end else begin
      m_bad_run   = bad ? m_bad_run + 1 : 0;
      m_still_run = same ? m_still_run + 1 : 0;
      if (m_bad_run == CC || m_still_run == WD) begin
        m_fault = 1;
        m_code  = (m_bad_run == CC) ? (c ? 1 : 2) : 3;
        if (m_count < 255) m_count++;
        m_snap = vec;
      end
    end
  endtask

  task automatic check_all();
    chk("issue", {31'd0, issue}, {31'd0, m_fault});
    chk("code", {30'd0, code}, m_code);
    chk("count", {24'd0, cnt}, m_count);
    chk("armed", {31'd0, armed}, {31'd0, m_armed});
`ifdef LIGHT_MONITOR_SNAPSHOT_EN
    chk("snapshot", {22'd0, snap}, {22'd0, m_snap});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [4:0] n, input logic [4:0] e, input int cycles);
    ns = n; ew = e;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic clear_pulse(input logic [4:0] n, input logic [4:0] e);
    ns = n; ew = e; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  function automatic logic [4:0] rand_lamp();
    logic [4:0] legal [6];
    legal[0] = 5'b00001; legal[1] = 5'b00010; legal[2] = 5'b00100;
    legal[3] = 5'b10001; legal[4] = 5'b01001; legal[5] = 5'b01010;
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return legal[$urandom_range(0, 5)];
  endfunction

  initial begin
    model_reset();
    ns = 5'b00010; ew = 5'b00001;
    #12;
    chk("rst_issue", {31'd0, issue}, 32'd0);
    chk("rst_code", {30'd0, code}, 32'd0);
    chk("rst_count", {24'd0, cnt}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Arming, then watchdog on constant lamps.
    for (int i = 1; i <= ARM; i++) begin
      tick();
      if (i == ARM - 1) chk("armed_early", {31'd0, armed}, 32'd0);
    end
    chk("armed_after_16", {31'd0, armed}, 32'd1);
    hold(5'b00010, 5'b00001, WD - 1);
    chk("wd_not_yet", {31'd0, issue}, 32'd0);
    tick();
    chk("wd_issue", {31'd0, issue}, 32'd1);
    chk("wd_code", {30'd0, code}, 32'd3);
    chk("wd_count", {24'd0, cnt}, 32'd1);

    // Conflict debounce: 3 cycles rejected, 4 cycles accepted.
    clear_pulse(5'b00010, 5'b00001);
    chk("clear_wd", {31'd0, issue}, 32'd0);
    hold(5'b00010, 5'b00010, 3);
    hold(5'b00010, 5'b00001, 1);
    chk("short_conflict", {31'd0, issue}, 32'd0);
    hold(5'b00010, 5'b00010, 4);
    chk("conflict_issue", {31'd0, issue}, 32'd1);
    chk("conflict_code", {30'd0, code}, 32'd1);

    // Illegal aspect, clear refused while still illegal, then accepted.
    clear_pulse(5'b00010, 5'b00001);
    hold(5'b00011, 5'b00001, 4);
    chk("illegal_code", {30'd0, code}, 32'd2);
    clear_pulse(5'b00011, 5'b00001);
    chk("clear_refused", {31'd0, issue}, 32'd1);
    chk("clear_refused_code", {30'd0, code}, 32'd2);
    clear_pulse(5'b00001, 5'b00001);
    chk("clear_ok_issue", {31'd0, issue}, 32'd0);
    chk("clear_ok_code", {30'd0, code}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ns = rand_lamp();
        ew = rand_lamp();
      end
      clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    clr = 1'b0;

    // Saturation of the fault counter.
    for (int i = 0; i < 260; i++) begin
      hold(5'b00010, 5'b00010, 4);
      clear_pulse(5'b00010, 5'b00001);
    end
    chk("count_saturated", {24'd0, cnt}, 32'd255);

    // Asynchronous reset while in FAULT.
    hold(5'b00010, 5'b00010, 4);
    chk("pre_reset_issue", {31'd0, issue}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_issue", {31'd0, issue}, 32'd0);
    chk("async_code", {30'd0, code}, 32'd0);
    chk("async_count", {24'd0, cnt}, 32'd0);
    chk("async_armed", {31'd0, armed}, 32'd0);
    tick();
    rst_n = 1'b1;
    hold(5'b00010, 5'b00001, ARM);
    chk("rearmed", {31'd0, armed}, 32'd1);

    // Snapshot capture and hold across clear.
    hold(5'b00100, 5'b01000, 4);
    chk("snap_fault_code", {30'd0, code}, 32'd1);
`ifdef LIGHT_MONITOR_SNAPSHOT_EN
    chk("snap_value", {22'd0, snap}, {22'd0, 10'b01000_00100});
`endif
    clear_pulse(5'b00001, 5'b00010);
    chk("snap_cleared_issue", {31'd0, issue}, 32'd0);
`ifdef LIGHT_MONITOR_SNAPSHOT_EN
    chk("snap_after_clear", {22'd0, snap}, {22'd0, 10'b01000_00100});
`endif
    hold(5'b00001, 5'b00010, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
